// File: rtl/vline_motion_ctrl.sv
// Vertical line motion controller: loads a start row, then steps a
// line counter up/down at a frame-divided rate, bouncing at limits.
module vline_motion_ctrl #(
  parameter int unsigned TOP_LIM      = 487,
  parameter int unsigned BOT_LIM      = 18,
  parameter int unsigned STEP_DIV     = 1,
  parameter int unsigned PIX_PER_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        go,
  input  logic        stop,
  input  logic        dir_init,
  input  logic [15:0] sw,
  input  logic [15:0] ycoord,
  input  logic        at_top,
  input  logic        at_bot,
  output logic        UP,
  output logic        DW,
  output logic        LD,
  output logic [15:0] load_val,
  output logic        dir,
  output logic        busy,
  output logic [7:0]  bounce_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_STEP = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam logic [15:0] TOP      = 16'(TOP_LIM);
  localparam logic [15:0] BOT      = 16'(BOT_LIM);
  localparam logic [7:0]  DIV_LAST = 8'(STEP_DIV - 1);
  localparam logic [3:0]  PIX      = 4'(PIX_PER_STEP);

  state_t      state_q;
  logic        ld_q;
  logic [15:0] load_val_q;
  logic        dir_q;
  logic [7:0]  bounce_q;
  logic [7:0]  div_q;
  logic [3:0]  pulse_q;

  logic        hit_top;
  logic        hit_bot;
  logic        in_step;
  logic        blocked;
  logic [15:0] load_d;
  logic [7:0]  bounce_d;

  assign hit_top = at_top | (ycoord >= TOP);
  assign hit_bot = at_bot | (ycoord <= BOT);
  assign in_step = (state_q == S_STEP);
  assign blocked = dir_q ? hit_top : hit_bot;

  // A blocked pulse-cycle turns the line around instead of moving it
  assign UP = in_step & dir_q & ~hit_top;
  assign DW = in_step & ~dir_q & ~hit_bot;

  always_comb begin
    load_d = sw;
    if (sw < BOT) begin
      load_d = BOT;
    end else if (sw > TOP) begin
      load_d = TOP;
    end
  end

  assign bounce_d = (bounce_q == 8'hFF) ? bounce_q : bounce_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ld_q       <= 1'b0;
      load_val_q <= '0;
      dir_q      <= 1'b1;
      bounce_q   <= '0;
      div_q      <= '0;
      pulse_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go && !stop) begin
            state_q    <= S_LOAD;
            ld_q       <= 1'b1;
            load_val_q <= load_d;
          end
        end
        S_LOAD: begin
          ld_q     <= 1'b0;
          dir_q    <= dir_init;
          bounce_q <= '0;
          div_q    <= '0;
          pulse_q  <= '0;
          state_q  <= stop ? S_HOLD : S_WAIT;
        end
        S_WAIT: begin
          if (stop) begin
            state_q <= S_HOLD;
          end else if (frame_tick) begin
            if (div_q == DIV_LAST) begin
              div_q   <= '0;
              pulse_q <= PIX;
              state_q <= S_STEP;
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
        end
        S_STEP: begin
          if (blocked) begin
            dir_q    <= ~dir_q;
            bounce_q <= bounce_d;
          end
          // Frame ticks landing here are dropped, not queued
          if (stop) begin
            pulse_q <= '0;
            state_q <= S_HOLD;
          end else begin
            pulse_q <= pulse_q - 4'd1;
            if (pulse_q <= 4'd1) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_HOLD: begin
          if (go && !stop) begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign LD         = ld_q;
  assign load_val   = load_val_q;
  assign dir        = dir_q;
  assign bounce_cnt = bounce_q;
  assign busy       = (state_q == S_LOAD) ||
                      (state_q == S_WAIT) ||
                      (state_q == S_STEP);

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Bench for vline_motion_ctrl: default instance plus a divided,
// multi-pixel instance sharing the same stimulus.
module tb_vline_motion_ctrl;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        go;
  logic        stop;
  logic        dir_init;
  logic [15:0] sw_r;
  logic [15:0] ycoord;
  logic        at_top;
  logic        at_bot;

  logic        up0, dw0, ld0, dir0, busy0;
  logic [15:0] lv0;
  logic [7:0]  bc0;
  logic        up1, dw1, ld1, dir1, busy1;
  logic [15:0] lv1;
  logic [7:0]  bc1;

  int n_chk;
  int n_pass;
  int up1_cnt;
  int base;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] sw;
    logic        di;
    logic [15:0] lv;
  } vec_t;

  vec_t tv[8];

  vline_motion_ctrl u0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .go(go), .stop(stop), .dir_init(dir_init),
    .sw(sw_r), .ycoord(ycoord), .at_top(at_top), .at_bot(at_bot),
    .UP(up0), .DW(dw0), .LD(ld0), .load_val(lv0),
    .dir(dir0), .busy(busy0), .bounce_cnt(bc0)
  );

  vline_motion_ctrl #(.STEP_DIV(3), .PIX_PER_STEP(4)) u1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .go(go), .stop(stop), .dir_init(dir_init),
    .sw(sw_r), .ycoord(ycoord), .at_top(at_top), .at_bot(at_bot),
    .UP(up1), .DW(dw1), .LD(ld1), .load_val(lv1),
    .dir(dir1), .busy(busy1), .bounce_cnt(bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go = 1'b0;
    stop = 1'b0;
    frame_tick = 1'b0;
    at_top = 1'b0;
    at_bot = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic [15:0] s, input logic d,
                       input logic [15:0] e);
    sw_r = s;
    dir_init = d;
    go = 1'b1;
    exp_q.push_back(e);
    tick();
    go = 1'b0;
    tick();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  // Scoreboard: every LD on the default instance must match a queued load
  always @(negedge clk) begin
    if (ld0) begin
      if (exp_q.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
      else chk("load_val", 32'(lv0), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (up1) up1_cnt++;
  end

  always @(negedge clk) begin
    n_chk++;
    assert (!((up0 && dw0) || (ld0 && (up0 || dw0)) ||
              (up1 && dw1) || (ld1 && (up1 || dw1))))
      n_pass++;
    else
      $display("FAIL excl: up0=%b dw0=%b ld0=%b up1=%b dw1=%b ld1=%b",
               up0, dw0, ld0, up1, dw1, ld1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    up1_cnt = 0;
    sw_r = '0;
    dir_init = 1'b0;
    ycoord = 16'd100;
    tv[0] = '{16'd100,   1'b1, 16'd100};
    tv[1] = '{16'd5,     1'b0, 16'd18};
    tv[2] = '{16'd600,   1'b1, 16'd487};
    tv[3] = '{16'd18,    1'b0, 16'd18};
    tv[4] = '{16'd487,   1'b1, 16'd487};
    tv[5] = '{16'd17,    1'b1, 16'd18};
    tv[6] = '{16'd488,   1'b0, 16'd487};
    tv[7] = '{16'hFFFF,  1'b0, 16'd487};

    do_reset();
    @(negedge clk);
    chk("rst_u0_flags", {up0, dw0, ld0, busy0, dir0}, 5'b00001);
    chk("rst_u0_lv", lv0, 0);
    chk("rst_u0_bc", bc0, 0);
    chk("rst_u1_flags", {up1, dw1, ld1, busy1, dir1}, 5'b00001);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      sw_r = tv[i].sw;
      dir_init = tv[i].di;
      go = 1'b1;
      exp_q.push_back(tv[i].lv);
      tick();
      go = 1'b0;
      @(negedge clk);
      chk("ld_high", ld0, 1);
      chk("busy_load", busy0, 1);
      tick();
      @(negedge clk);
      chk("ld_once", ld0, 0);
      chk("dir_init", dir0, 32'(tv[i].di));
      chk("busy_wait", busy0, 1);
    end

    do_reset();
    ycoord = 16'd100;
    start(16'd100, 1'b1, 16'd100);
    frame();
    @(negedge clk);
    chk("first_up", {up0, dw0}, 2'b10);
    tick();
    @(negedge clk);
    chk("up_single", up0, 0);
    ycoord = 16'd487;
    frame();
    @(negedge clk);
    chk("no_up_at_top", up0, 0);
    tick();
    @(negedge clk);
    chk("dir_after_top", dir0, 0);
    chk("bounce_1", bc0, 1);
    ycoord = 16'd300;
    frame();
    @(negedge clk);
    chk("dw_after_bounce", dw0, 1);
    tick();
    ycoord = 16'd200;
    at_bot = 1'b1;
    frame();
    @(negedge clk);
    chk("no_dw_at_bot", dw0, 0);
    tick();
    @(negedge clk);
    chk("dir_after_bot", dir0, 1);
    chk("bounce_2", bc0, 2);
    at_bot = 1'b0;

    do_reset();
    ycoord = 16'd100;
    start(16'd100, 1'b1, 16'd100);
    base = up1_cnt;
    frame();
    repeat (5) tick();
    frame();
    repeat (5) tick();
    @(negedge clk);
    chk("div_no_early", up1_cnt - base, 0);
    chk("busy_div", busy1, 1);
    frame();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pix_burst", up1, (i < 4) ? 1 : 0);
      tick();
    end

    frame();
    frame();
    frame();
    base = up1_cnt;
    @(negedge clk);
    tick();
    stop = 1'b1;
    @(negedge clk);
    chk("second_pulse", up1, 1);
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("hold_busy", busy1, 0);
    frame();
    frame();
    frame();
    tick();
    @(negedge clk);
    chk("stop_pulses", up1_cnt - base, 2);
    chk("hold_dir", dir1, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("resume_busy", busy1, 1);
    chk("resume_no_ld", ld1, 0);
    chk("resume_dir", dir1, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("go_busy_ign", {ld1, busy1}, 2'b01);

    frame();
    frame();
    frame();
    @(negedge clk);
    chk("in_step", up1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_flags", {up1, dw1, ld1, busy1, dir1}, 5'b00001);
    chk("rst_mid_lv", lv1, 0);
    chk("rst_mid_bc", bc1, 0);

    start(16'd100, 1'b1, 16'd100);
    base = up1_cnt;
    frame_tick = 1'b1;
    repeat (14) tick();
    frame_tick = 1'b0;
    chk("tick_in_step_drop", up1_cnt - base, 8);

    do_reset();
    ycoord = 16'd100;
    start(16'd100, 1'b1, 16'd100);
    at_top = 1'b1;
    at_bot = 1'b1;
    frame();
    tick();
    @(negedge clk);
    chk("sat_first", {24'd0, bc0, 7'd0, dir0}, {24'd0, 8'd1, 8'd0});
    repeat (299) begin
      frame();
      tick();
    end
    @(negedge clk);
    chk("bounce_sat", bc0, 255);
    chk("sat_no_move", {up0, dw0}, 2'b00);
    at_top = 1'b0;
    at_bot = 1'b0;

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
